// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the ALU controller slice.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
    localparam logic [2:0] OP_SHR1 = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: wrapping arithmetic, logic ops, 1-bit shifts and unsigned set-less-than.
// Latency: 0 cycles. Backpressure: none, purely combinational.
// Results wrap modulo 2^WIDTH; zero flags an all-zero result.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL1: result = a << 1;
            OP_SHR1: result = a >> 1;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_ctrl_regfile.sv
// Operand register file: two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles, write visible after the next clock edge.
// Backpressure: none; a write is taken on every cycle we is high unless rst is high.
module alu_ctrl_regfile #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       raddr_a,
    input  logic [1:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [NREG];
    logic [WIDTH-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// ALU command controller: loads immediates or issues register ops to an external ALU.
// Latency: load response 1 cycle after accept, ALU response 2 cycles after accept.
// Backpressure: one command in flight; cmd_ready low until the response is taken by rsp_ready.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_rd,
    input  logic [1:0]       cmd_rs1,
    input  logic [1:0]       cmd_rs2,
    input  logic             cmd_imm_en,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [1:0]       rsp_rd
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [1:0]       rd_q, rd_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [1:0]       rsp_rd_q, rsp_rd_d;

    logic             rf_we;
    logic [1:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rf_rdata_a, rf_rdata_b;

    alu_ctrl_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (cmd_rs1),
        .raddr_b (cmd_rs2),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_rd_d   = rsp_rd_q;
        rf_we      = 1'b0;
        rf_waddr   = rd_q;
        rf_wdata   = alu_result;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_load) begin
                        rf_we      = 1'b1;
                        rf_waddr   = cmd_rd;
                        rf_wdata   = cmd_imm;
                        rsp_data_d = cmd_imm;
                        rsp_zero_d = (cmd_imm == '0);
                        rsp_rd_d   = cmd_rd;
                        state_d    = ST_RESP;
                    end else begin
                        // Operands are captured here so rd aliasing rs1/rs2 cannot disturb them.
                        alu_a_d  = rf_rdata_a;
                        alu_b_d  = cmd_imm_en ? cmd_imm : rf_rdata_b;
                        alu_op_d = cmd_op;
                        rd_d     = cmd_rd;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                rf_we      = 1'b1;
                rsp_data_d = alu_result;
                rsp_zero_d = alu_zero;
                rsp_rd_d   = rd_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign rsp_data = rsp_data_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_rd   = rsp_rd_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl wired to the combinational alu, WIDTH=8.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic       cmd_imm_en;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic [1:0] rsp_rd;

    int n_chk  = 0;
    int n_pass = 0;

    alu_ctrl #(.WIDTH(8), .NREG(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_rd     (rsp_rd)
    );

    alu #(.WIDTH(8)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Issue one command, check latency and response, optionally stall the response
    // for `hold` cycles while offering a competing load of 7 into r0.
    task automatic run_cmd(input string tag, input logic ld, input logic [2:0] op,
                           input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic ie, input logic [7:0] imm,
                           input logic [7:0] exp_d, input logic exp_z, input int hold);
        int n;
        int lat;
        logic [2:0] op_snap;
        @(negedge clk);
        cmd_load = ld; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, ld ? 1 : 2);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_zero"}, rsp_zero, exp_z);
        chk({tag, "_rd"}, rsp_rd, rd);
        op_snap = alu_op;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_load = 1'b1; cmd_rd = 2'd0; cmd_imm = 8'd7;
            @(posedge clk);
            #1;
            chk({tag, "_hold_vld"}, rsp_valid, 1);
            chk({tag, "_hold_rdy"}, cmd_ready, 0);
            chk({tag, "_hold_data"}, rsp_data, exp_d);
            chk({tag, "_hold_rd"}, rsp_rd, rd);
            chk({tag, "_hold_op"}, alu_op, op_snap);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_released"}, rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_rd = '0;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm_en = 1'b0; cmd_imm = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_rd", rsp_rd, 0);

        //       tag         ld   op       rd    rs1   rs2   ie   imm     exp   z  hold
        run_cmd("ld_r0",    1, OP_ADD,  2'd0, 2'd0, 2'd0, 0, 8'd200, 8'd200, 0, 0);
        run_cmd("ld_r1",    1, OP_ADD,  2'd1, 2'd0, 2'd0, 0, 8'd100, 8'd100, 0, 0);
        run_cmd("add",      0, OP_ADD,  2'd2, 2'd0, 2'd1, 0, 8'd0,   8'd44,  0, 0);
        chk("add_alu_a", alu_a, 200);
        chk("add_alu_b", alu_b, 100);
        chk("add_alu_op", alu_op, OP_ADD);
        run_cmd("sub_self", 0, OP_SUB,  2'd3, 2'd1, 2'd1, 0, 8'd0,   8'd0,   1, 0);
        run_cmd("slt_01",   0, OP_SLT,  2'd3, 2'd0, 2'd1, 0, 8'd0,   8'd0,   1, 0);
        run_cmd("slt_10",   0, OP_SLT,  2'd3, 2'd1, 2'd0, 0, 8'd0,   8'd1,   0, 0);
        run_cmd("xor_imm",  0, OP_XOR,  2'd1, 2'd1, 2'd0, 1, 8'hFF,  8'd155, 0, 0);
        run_cmd("add_self", 0, OP_ADD,  2'd1, 2'd1, 2'd1, 0, 8'd0,   8'd54,  0, 0);
        run_cmd("or_stall", 0, OP_OR,   2'd2, 2'd0, 2'd1, 0, 8'd0,   8'd254, 0, 5);
        run_cmd("r0_kept",  0, OP_ADD,  2'd3, 2'd0, 2'd0, 1, 8'd0,   8'd200, 0, 0);
        run_cmd("and",      0, OP_AND,  2'd2, 2'd0, 2'd1, 0, 8'd0,   8'd0,   1, 0);

        // Abandon an ALU command by resetting while it sits in EXEC.
        @(negedge clk);
        cmd_load = 1'b0; cmd_op = OP_XOR; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd0;
        cmd_imm_en = 1'b1; cmd_imm = 8'h0F; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("exec_cmd_ready", cmd_ready, 0);
        chk("exec_rsp_valid", rsp_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("exec_rst_rsp_valid", rsp_valid, 0);
        chk("exec_rst_alu_a", alu_a, 0);
        rst = 1'b0;
        chk("exec_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        chk("exec_rst_no_rsp", rsp_valid, 0);
        run_cmd("r2_cleared", 0, OP_ADD, 2'd3, 2'd2, 2'd0, 1, 8'd0, 8'd0, 1, 0);

        run_cmd("ld_81",    1, OP_ADD,  2'd1, 2'd0, 2'd0, 0, 8'h81,  8'h81,  0, 0);
        run_cmd("shl1",     0, OP_SHL1, 2'd2, 2'd1, 2'd0, 0, 8'd0,   8'h02,  0, 0);
        run_cmd("shr1",     0, OP_SHR1, 2'd2, 2'd1, 2'd0, 0, 8'd0,   8'h40,  0, 0);
        run_cmd("ld_zero",  1, OP_ADD,  2'd3, 2'd0, 2'd0, 0, 8'd0,   8'd0,   1, 0);
        chk("ld_keeps_alu_op", alu_op, OP_SHR1);
        chk("ld_keeps_alu_a", alu_a, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
